skew_loader: RTL and testbench

SKEW_LOADER -- requirements
Module: skew_loader

---
 rtl/skew_loader.sv | 150 +++++++++++++++
 tb/tb_skew_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_loader.sv
// skew_loader: accepts one tile of LANES*DEPTH words from a valid/ready
// stream and writes them round-robin into LANES skewed input buffers.
// It then issues DEPTH+LANES-1 common read strobes so every lane drains its
// leading padding plus its DEPTH data words, and finally pulses done.
module skew_loader #(
    parameter int WORDLEN = 8,
    parameter int LANES   = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic               s_valid,
    input  logic [WORDLEN-1:0] s_data,
    output logic               s_ready,
    output logic [LANES-1:0]   buf_write,
    output logic [WORDLEN-1:0] buf_din,
    output logic               buf_read,
    output logic               busy,
    output logic               done
);

    // Lane i carries i padding words, so the deepest lane needs DEPTH+LANES-1 reads.
    localparam int READS = DEPTH + LANES - 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW    = (READS > 1) ? $clog2(READS + 1) : 1;

    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [VW-1:0] VEC_LAST  = VW'(DEPTH - 1);
    localparam logic [DW-1:0] READ_LAST = DW'(READS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LW-1:0]      r_lane_cnt;
    logic [VW-1:0]      r_vec_cnt;
    logic [DW-1:0]      r_drain_cnt;
    logic [LANES-1:0]   r_buf_write;
    logic [WORDLEN-1:0] r_buf_din;
    logic               r_buf_read;

    logic               w_hs;
    logic               w_last_word;
    logic               w_drain_end;
    logic [LANES-1:0]   w_lane_onehot;

    assign s_ready     = (r_state == ST_LOAD);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign buf_write   = r_buf_write;
    assign buf_din     = r_buf_din;
    assign buf_read    = r_buf_read;

    assign w_hs        = s_valid && s_ready;
    assign w_last_word = (r_lane_cnt == LANE_LAST) && (r_vec_cnt == VEC_LAST);
    assign w_drain_end = (r_drain_cnt == READ_LAST);

    // Decode the current lane into its write strobe.
    always_comb begin
        w_lane_onehot = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_onehot[i] = (r_lane_cnt == LW'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_LOAD;
            ST_LOAD:  if (w_hs && w_last_word) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_drain_end) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        if (abort) begin
            w_next_state = ST_IDLE;
        end
    end

    // Counters and registered buffer strobes/data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lane_cnt  <= '0;
            r_vec_cnt   <= '0;
            r_drain_cnt <= '0;
            r_buf_write <= '0;
            r_buf_din   <= '0;
            r_buf_read  <= 1'b0;
        end else begin
            r_buf_write <= '0;
            if (abort) begin
                r_lane_cnt  <= '0;
                r_vec_cnt   <= '0;
                r_drain_cnt <= '0;
                r_buf_read  <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        r_drain_cnt <= '0;
                        r_buf_read  <= 1'b0;
                        if (w_hs) begin
                            r_buf_din   <= s_data;
                            r_buf_write <= w_lane_onehot;
                            if (r_lane_cnt == LANE_LAST) begin
                                r_lane_cnt <= '0;
                                r_vec_cnt  <= (r_vec_cnt == VEC_LAST) ? '0 : r_vec_cnt + VW'(1);
                            end else begin
                                r_lane_cnt <= r_lane_cnt + LW'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // The first drain cycle is the final write cycle, so reads start one edge later.
                        if (w_drain_end) begin
                            r_buf_read <= 1'b0;
                        end else begin
                            r_buf_read  <= 1'b1;
                            r_drain_cnt <= r_drain_cnt + DW'(1);
                        end
                    end
                    default: begin
                        r_lane_cnt  <= '0;
                        r_vec_cnt   <= '0;
                        r_drain_cnt <= '0;
                        r_buf_read  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_skew_loader.sv
// Testbench for skew_loader (LANES=4, DEPTH=8, WORDLEN=8).
// The reference tracks accepted words by index: word k lands in lane k mod
// LANES one cycle after acceptance, and a tile of LANES*DEPTH words is
// followed by DEPTH+LANES-1 read cycles, one done cycle, then idle.
module tb_skew_loader;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int D  = 8;
    localparam int NW = L * D;
    localparam int NR = D + L - 1;
    localparam int OW = 4 + L + W;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         abort;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic [L-1:0] buf_write;
    logic [W-1:0] buf_din;
    logic         buf_read;
    logic         busy;
    logic         done;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] g_din;

    always #5 clk = ~clk;

    skew_loader #(.WORDLEN(W), .LANES(L), .DEPTH(D)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .abort    (abort),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .buf_write(buf_write),
        .buf_din  (buf_din),
        .buf_read (buf_read),
        .busy     (busy),
        .done     (done)
    );

    // Observed vector layout: {s_ready, busy, done, buf_read, buf_write, buf_din}
    wire [OW-1:0] obs = {s_ready, busy, done, buf_read, buf_write, buf_din};

    // Loads one tile. vmode: 0 continuous valid, 1 toggling, 2 random.
    // stop_reads >= 0 returns in the middle of the drain after that many reads.
    task automatic run_tile(input int vmode, input bit seq, input bit noise,
                            input int stop_reads, output int ncyc);
        int           acc;
        int           cyc;
        bit           v;
        logic [L-1:0] ebw;
        logic [W-1:0] d;
        logic [OW-1:0] e;
        ncyc = 0;
        @(negedge clk);
        start = 1'b1; s_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        acc = 0; cyc = 0; ebw = '0;
        forever begin
            e = {(acc < NW) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, ebw, g_din};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL load_cycle%0d (vmode %0d): got %h expected %h", cyc, vmode, obs, e);
            end
            if (acc == NW) break;
            if (cyc >= 400) begin
                n_bad++;
                $display("FAIL load_timeout: accepted %0d expected %0d", acc, NW);
                break;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = seq ? W'(acc + 1) : W'($urandom_range(0, 255));
            s_valid = v; s_data = d;
            if (noise) start = 1'($urandom_range(0, 1));
            if (v) begin
                ebw   = L'(1) << (acc % L);
                g_din = d;
                acc++;
            end else begin
                ebw = '0;
            end
            @(negedge clk);
            cyc++;
        end
        ncyc = cyc;
        start = 1'b0;
        for (int r = 1; r <= NR; r++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = W'($urandom_range(0, 255));
            @(negedge clk);
            e = {1'b0, 1'b1, 1'b0, 1'b1, {L{1'b0}}, g_din};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL drain_read%0d: got %h expected %h", r, obs, e);
            end
            if (stop_reads >= 0 && r >= stop_reads) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        @(negedge clk);
        e = {1'b0, 1'b1, 1'b1, 1'b0, {L{1'b0}}, g_din};
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL done_pulse: got %h expected %h", obs, e);
        end
        @(negedge clk);
        e = {1'b0, 1'b0, 1'b0, 1'b0, {L{1'b0}}, g_din};
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL idle_after_done: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        g_din = '0;
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_immediate: got %h expected %h", obs, {OW{1'b0}});
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected %h", obs, {OW{1'b0}});
        end
        rstn = 1'b1;
    endtask

    task automatic test_idle_ignore();
        logic [OW-1:0] e;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = W'($urandom_range(0, 255));
            @(negedge clk);
            e = {1'b0, 1'b0, 1'b0, 1'b0, {L{1'b0}}, g_din};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL idle_valid_ignored%0d: got %h expected %h", i, obs, e);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_continuous();
        int n;
        run_tile(0, 1'b1, 1'b0, -1, n);
        n_cmp++;
        if (n !== NW) begin
            n_bad++;
            $display("FAIL continuous_cycles: got %0d expected %0d", n, NW);
        end
    endtask

    task automatic test_toggle();
        int n;
        run_tile(1, 1'b0, 1'b0, -1, n);
        n_cmp++;
        if (n !== 2 * NW - 1) begin
            n_bad++;
            $display("FAIL toggle_cycles: got %0d expected %0d", n, 2 * NW - 1);
        end
    endtask

    task automatic test_start_during_load();
        int n;
        run_tile(2, 1'b0, 1'b1, -1, n);
        run_tile(2, 1'b0, 1'b1, -1, n);
    endtask

    task automatic test_abort();
        int            n;
        logic [OW-1:0] e;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            s_valid = 1'b1;
            s_data  = W'($urandom_range(0, 255));
            g_din   = s_data;
            @(negedge clk);
        end
        e = {1'b1, 1'b1, 1'b0, 1'b0, L'(1) << (12 % L), g_din};
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL abort_word13: got %h expected %h", obs, e);
        end
        abort = 1'b1; start = 1'b1; s_valid = 1'b1;
        s_data = ~g_din;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; s_valid = 1'b0;
        e = {1'b0, 1'b0, 1'b0, 1'b0, {L{1'b0}}, g_din};
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL abort_to_idle: got %h expected %h", obs, e);
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL abort_stays_idle: got %h expected %h", obs, e);
        end
        run_tile(0, 1'b0, 1'b0, -1, n);
        n_cmp++;
        if (n !== NW) begin
            n_bad++;
            $display("FAIL abort_reload_cycles: got %0d expected %0d", n, NW);
        end
    endtask

    task automatic test_reset_drain();
        int n;
        run_tile(0, 1'b0, 1'b0, 5, n);
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_in_drain: got %h expected %h", obs, {OW{1'b0}});
        end
        g_din = '0;
        #1;
        rstn = 1'b1;
        for (int i = 0; i < NR + 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== '0) begin
                n_bad++;
                $display("FAIL post_reset_idle%0d: got %h expected %h", i, obs, {OW{1'b0}});
            end
        end
        run_tile(2, 1'b0, 1'b0, -1, n);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_continuous();
        test_toggle();
        test_start_during_load();
        test_abort();
        test_reset_drain();
        test_continuous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
